multiword_add_seq: RTL and testbench
====================================

// Module: multiword_add_seq
// PURPOSE
//   Sequencer for a single 4-bit ripple-add slice, reused over WORDS nibbles to add wide operands.
//   - Latches operands, feeds one nibble per cycle (LSB first) through the slice and registers the carry between nibbles.
//   - Returns the full-width sum and carry-out through a valid/ready handshake.
//   - Sits between the operand producer and any consumer that trades latency for one narrow adder.
// PARAMETERS
//   WORDS    4    number of 4-bit nibbles per operand (>=1); operand width W = 4*WORDS
// PORTS
//   clk        in   1     clock, all state updates on rising edge
//   rst        in   1     synchronous reset, active-high
//   in_valid   in   1     operands/cin valid
//   in_ready   out  1     block can accept operands (high only in IDLE)
//   r1         in   W     operand A
//   r2         in   W     operand B
//   cin        in   1     carry into nibble 0
//   out_valid  out  1     s/cout valid (high only in DONE)
//   out_ready  in   1     consumer takes result
//   s          out  W     sum
//   cout       out  1     carry out of top nibble
//   busy       out  1     high in RUN
// BEHAVIOUR
//   Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, s=0, cout=0, cnt=0, carry=0.
//   Reset mid-operation aborts with no partial result presented and returns to IDLE with these values.
//   State machine:
//   - IDLE: in_valid&in_ready at an edge latches r1, r2 and carry<=cin; s<=0, cnt<=0, state goes to RUN.
//   - RUN: each edge writes s[4*cnt+:4] <= slice sum of nibble cnt plus carry; carry <= slice carry-out; cnt++.
//     When cnt==WORDS-1: cout <= slice carry-out, state goes to DONE.
//     in_valid is ignored; latched operands are not re-sampled.
//   - DONE: s/cout held stable while out_valid=1 and out_ready=0.
//     out_valid&out_ready at an edge moves to IDLE; in_ready is 0 during DONE (no same-cycle reload).
//   Latency: out_valid rises exactly WORDS edges after the accept edge.
//     Throughput is one result per WORDS+2 cycles with out_ready held high.
//   Width rules:
//   - cnt width = max(1, $clog2(WORDS)).
//   - Slice is 4+4+1 -> 5 bits, split {carry, sum[3:0]}: carry is the MSB and sum is the low nibble.
//   - Result is modulo 2^W with cout as bit W.
//   Boundary cases:
//   - WORDS=1: RUN lasts one cycle.
//   - All-ones operands with cin=1 propagate carry through every nibble.
//   - cnt never exceeds WORDS-1.
// CONFIGURATION
//   SUBTRACT_EN defined:
//   - Adds input port sub (1 bit), latched with the operands.
//   - sub=1 feeds ~nibble of r2 to the slice and forces the initial carry to 1 (cin ignored).
//     Result is r1-r2 mod 2^W; cout=1 means no borrow.
//   - sub=0 behaves exactly as the plain adder.
//   SUBTRACT_EN undefined: no sub port; add-only datapath.
// STRUCTURE
//   Shared package: state enum {IDLE, RUN, DONE} and localparam SLICE_W=4.
//   One sub-module: nibble_add (combinational 4-bit slice: a[3:0], b[3:0], ci -> sum[3:0], co).
//   The FSM, cnt, carry and the operand/result registers live in multiword_add_seq.
// TESTING (WORDS=4 unless noted)
//   1. Reset with in_valid=1 -> in_ready=1, out_valid=0, s=0, cout=0; nothing is accepted while rst=1.
//   2. r1=16'h1234, r2=16'h4321, cin=0 -> out_valid 4 edges after accept, s=16'h5555, cout=0.
//   3. r1=16'hFFFF, r2=16'h0001, cin=0 -> s=16'h0000, cout=1. Repeat with r2=0, cin=1 -> same result.
//   4. Hold out_ready=0 for 5 cycles in DONE -> s/cout stable, in_ready=0.
//      Also pulse in_valid with new operands during RUN -> result unaffected.
//   5. Assert rst at the 2nd RUN cycle -> next cycle is IDLE with all outputs at reset values.
//      A new accepted operation then completes correctly.
//   6. SUBTRACT_EN: r1=16'h0005, r2=16'h0007, sub=1 -> s=16'hFFFE, cout=0.
//      WORDS=1 build: 4'hF+4'h1 -> s=4'h0, cout=1 after 1 edge.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : multiword_add_seq_pkg
// Brief  : Shared types and constants for the nibble-serial multiword adder.
// Rev    : 1.0 - initial release
// ============================================================================
package multiword_add_seq_pkg;

  // Width of the single adder slice that is reused for every nibble.
  localparam int SLICE_W = 4;

  // Sequencer states: waiting for operands, stepping nibbles, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : multiword_add_seq_pkg
`default_nettype wire

// File: rtl/multiword_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module : multiword_add_seq_if
// Brief  : Operand/result handshake bundle for multiword_add_seq.
//          The optional sub signal exists only when SUBTRACT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
interface multiword_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = multiword_add_seq_pkg::SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         busy;
`ifdef SUBTRACT_EN
  logic         sub;
`endif

  // Adder side: consumes operands, produces the result.
  modport slave (
    input  in_valid, r1, r2, cin, out_ready,
    output in_ready, out_valid, s, cout, busy
`ifdef SUBTRACT_EN
    , input sub
`endif
  );

  // Producer/consumer side.
  modport master (
    output in_valid, r1, r2, cin, out_ready,
    input  in_ready, out_valid, s, cout, busy
`ifdef SUBTRACT_EN
    , output sub
`endif
  );

endinterface : multiword_add_seq_if
`default_nettype wire

// File: rtl/multiword_add_seq_nibble_add.sv
`default_nettype none
// ============================================================================
// Module : nibble_add
// Brief  : Combinational 4-bit ripple slice: {co, sum} = a + b + ci.
// Rev    : 1.0 - initial release
// ============================================================================
module nibble_add
  import multiword_add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_ci,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_co
);

  logic [SLICE_W:0] w_total;

  // Carry lands in the MSB of the 5-bit total, sum in the low nibble.
  assign w_total        = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_ci};
  assign {o_co, o_sum}  = w_total;

endmodule : nibble_add
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module : multiword_add_seq
// Brief  : Adds two WORDS*4-bit operands by stepping one 4-bit slice over the
//          nibbles LSB first, carrying between nibbles in a register. Result
//          is offered through a valid/ready handshake.
//          Optional macro SUBTRACT_EN adds a latched sub control that
//          computes r1 - r2 (cout=1 means no borrow).
// Rev    : 1.0 - initial release
// ============================================================================
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus
);

  localparam int W     = SLICE_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WORDS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_s;
  logic               r_cout;
`ifdef SUBTRACT_EN
  logic               r_sub;
`endif

  logic               w_accept;
  logic               w_last;
  logic               w_init_carry;
  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_sum;
  logic               w_co;
  logic [W-1:0]       w_s_next;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == c_LAST);

`ifdef SUBTRACT_EN
  // Subtraction is a + ~b + 1, so the initial carry is forced high.
  assign w_init_carry = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_init_carry = bus.cin;
`endif

  // Pick the current nibble of each operand and merge the slice sum into the result.
  always_comb begin
    w_a_nib  = '0;
    w_b_nib  = '0;
    w_s_next = r_s;
    for (int i = 0; i < WORDS; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_nib = r_a[i*SLICE_W +: SLICE_W];
        w_b_nib = r_b[i*SLICE_W +: SLICE_W];
        w_s_next[i*SLICE_W +: SLICE_W] = w_sum;
      end
    end
`ifdef SUBTRACT_EN
    if (r_sub) begin
      w_b_nib = ~w_b_nib;
    end
`endif
  end

  nibble_add u_slice (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_ci  (r_carry),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand latch, nibble counter, inter-nibble carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
`ifdef SUBTRACT_EN
      r_sub   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.r1;
      r_b     <= bus.r2;
      r_carry <= w_init_carry;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SUBTRACT_EN
      r_sub   <= bus.sub;
`endif
    end else if (r_state == RUN) begin
      r_s     <= w_s_next;
      r_carry <= w_co;
      if (w_last) begin
        // Counter parks at zero so it never exceeds WORDS-1.
        r_cout <= w_co;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.s         = r_s;
  assign bus.cout      = r_cout;

endmodule : multiword_add_seq
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_multiword_add_seq
// Brief  : Self-checking bench for multiword_add_seq (WORDS=4 main instance,
//          WORDS=1 side instance). Honours SUBTRACT_EN when defined.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_s;
    logic         exp_cout;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  multiword_add_seq_if #(.WORDS(WORDS)) bus ();
  multiword_add_seq_if #(.WORDS(1))     bus1 ();

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multiword_add_seq #(.WORDS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, bit W is the carry out.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic set_sub(input logic sb);
`ifdef SUBTRACT_EN
    bus.sub = sb;
`else
    if (sb) $display("note: sub requested without SUBTRACT_EN");
`endif
  endtask

  // One complete transaction: accept, count latency, check, hold, consume.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input logic [W:0] exp, input int hold,
                        input logic pulse, input string tag);
    int n;
    @(negedge clk);
    check($sformatf("%s in_ready_idle", tag), 32'(bus.in_ready), 32'd1);
    bus.r1 = a; bus.r2 = b; bus.cin = ci; set_sub(sb);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (pulse) begin
      bus.r1  = W'($urandom);
      bus.r2  = W'($urandom);
      bus.cin = ~ci;
      set_sub(~sb);
    end else begin
      bus.in_valid = 1'b0;
    end
    check($sformatf("%s busy_run", tag), {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("%s latency", tag), 32'(n), 32'(WORDS));
    check($sformatf("%s result", tag), 32'({bus.cout, bus.s}), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s hold%0d", tag, h),
            32'({bus.out_valid, bus.in_ready, bus.cout, bus.s}),
            32'({1'b1, 1'b0, exp}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check($sformatf("%s consumed", tag), 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, 32'({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.s}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.r1 = 16'hAAAA; bus.r2 = 16'h5555; bus.cin = 1'b1;
    bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.r1 = '0; bus1.r2 = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
`ifdef SUBTRACT_EN
    bus.sub = 1'b0; bus1.sub = 1'b0;
`endif

    // Reset held with in_valid high: nothing may be accepted.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset_hold");
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("after_reset");

    // Directed vector table.
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0});
`ifdef SUBTRACT_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             {vecs[i].exp_cout, vecs[i].exp_s}, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure for 5 cycles plus in_valid noise during RUN.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 16'h5555}, 5, 1'b1, "hold_pulse");

    // Reset on the second RUN cycle aborts the operation.
    @(negedge clk);
    bus.r1 = 16'h1111; bus.r2 = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("abort_reset");
    rst = 1'b0;
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, {1'b1, 16'h0000}, 1, 1'b0, "post_abort");

    // Randomized operations against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SUBTRACT_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (k % 8 == 0) begin
        ra = '1;
        rb = W'(k / 8);
      end
      run_op(ra, rb, rc, rs, ref_add(ra, rb, rc, rs), int'($urandom_range(0, 3)),
             1'($urandom), $sformatf("rnd%0d", k));
    end

    // WORDS=1 instance: single-cycle RUN.
    @(negedge clk);
    bus1.r1 = 4'hF; bus1.r2 = 4'h1; bus1.cin = 1'b0; bus1.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("w1_run", 32'({bus1.busy, bus1.out_valid}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    check("w1_result", 32'({bus1.out_valid, bus1.cout, bus1.s}), 32'({1'b1, 1'b1, 4'h0}));
    bus1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.out_ready = 1'b0;
    check("w1_consumed", 32'({bus1.out_valid, bus1.in_ready}), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multiword_add_seq
`default_nettype wire
